regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the processor register file between two writeback requesters: req0 is the ALU/execute writeback, req1 is the load/CSR writeback.
- Arbitrates each cycle with valid/ready handshakes and selectable priority.
- Registers the winning write and drives the register file's wen/waddr/wdata one cycle later.
- Accepts writes to register 0 but suppresses them.

---
 rtl/regfile_wb_arbiter_if.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 79 +++++++
 tb/tb_regfile_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two register-file writers, the arbiter and the register file write port.
// The arbiter side uses the slave modport; the requester/register-file side uses the master modport.
interface regfile_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  last_grant;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  rf_wen, rf_waddr, rf_wdata, last_grant
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output rf_wen, rf_waddr, rf_wdata, last_grant
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the register file write port; registered write, r0 writes dropped.
// Define RF_WB_ARB_STATS_EN to add the saturating conflict_cnt output.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef RF_WB_ARB_STATS_EN
    regfile_wb_arbiter_if.slave  io_wb,
    output logic [15:0]          conflict_cnt
`else
    regfile_wb_arbiter_if.slave  io_wb
`endif
);

    logic                  w_gnt0_p0;
    logic                  w_gnt1_p0;
    logic                  w_any_p0;
    logic                  w_r0_wins_tie_p0;
    logic [ADDR_WIDTH-1:0] w_addr_p0;
    logic [DATA_WIDTH-1:0] w_data_p0;

    logic                  r_wen_p1;
    logic [ADDR_WIDTH-1:0] r_waddr_p1;
    logic [DATA_WIDTH-1:0] r_wdata_p1;
    logic                  r_last_grant;

    // Stage p0: combinational grant; a tie goes to req0 under fixed priority or when req1 won last.
    always_comb begin
        w_r0_wins_tie_p0 = (FIXED_PRIO != 0) || r_last_grant;
        w_gnt0_p0 = !rst && io_wb.req0_valid && (!io_wb.req1_valid || w_r0_wins_tie_p0);
        w_gnt1_p0 = !rst && io_wb.req1_valid && !(io_wb.req0_valid && w_r0_wins_tie_p0);
        w_any_p0  = w_gnt0_p0 || w_gnt1_p0;
        w_addr_p0 = w_gnt1_p0 ? io_wb.req1_addr : io_wb.req0_addr;
        w_data_p0 = w_gnt1_p0 ? io_wb.req1_data : io_wb.req0_data;
    end

    assign io_wb.req0_ready = w_gnt0_p0;
    assign io_wb.req1_ready = w_gnt1_p0;

    // Stage p1: registered write port; a write to register 0 is accepted but never enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen_p1     <= 1'b0;
            r_waddr_p1   <= '0;
            r_wdata_p1   <= '0;
            r_last_grant <= 1'b1;
        end else if (w_any_p0) begin
            r_wen_p1     <= (w_addr_p0 != '0);
            r_waddr_p1   <= w_addr_p0;
            r_wdata_p1   <= w_data_p0;
            r_last_grant <= w_gnt1_p0;
        end else begin
            r_wen_p1     <= 1'b0;
        end
    end

    assign io_wb.rf_wen     = r_wen_p1;
    assign io_wb.rf_waddr   = r_waddr_p1;
    assign io_wb.rf_wdata   = r_wdata_p1;
    assign io_wb.last_grant = r_last_grant;

`ifdef RF_WB_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (io_wb.req0_valid && io_wb.req1_valid && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: one round-robin and one fixed-priority instance, directed cases then
// random traffic, both compared every cycle against a behavioural model of the grant rules.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) wb_rr ();
    regfile_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) wb_fp ();

`ifdef RF_WB_ARB_STATS_EN
    logic [15:0] cnt_rr;
    logic [15:0] cnt_fp;
    regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst), .io_wb(wb_rr), .conflict_cnt(cnt_rr));
    regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst), .io_wb(wb_fp), .conflict_cnt(cnt_fp));
`else
    regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst), .io_wb(wb_rr));
    regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst), .io_wb(wb_fp));
`endif

    // Per-instance stimulus: index 0 drives the round-robin DUT, index 1 the fixed-priority DUT.
    logic        v0 [2];
    logic        v1 [2];
    logic [4:0]  a0 [2];
    logic [4:0]  a1 [2];
    logic [31:0] d0 [2];
    logic [31:0] d1 [2];

    assign wb_rr.req0_valid = v0[0];
    assign wb_rr.req0_addr  = a0[0];
    assign wb_rr.req0_data  = d0[0];
    assign wb_rr.req1_valid = v1[0];
    assign wb_rr.req1_addr  = a1[0];
    assign wb_rr.req1_data  = d1[0];
    assign wb_fp.req0_valid = v0[1];
    assign wb_fp.req0_addr  = a0[1];
    assign wb_fp.req0_data  = d0[1];
    assign wb_fp.req1_valid = v1[1];
    assign wb_fp.req1_addr  = a1[1];
    assign wb_fp.req1_data  = d1[1];

    // Reference model state.
    logic        m_last  [2];
    logic        m_wen   [2];
    logic [4:0]  m_waddr [2];
    logic [31:0] m_wdata [2];
    int          m_cnt   [2];
    int          g       [2];

    // Register file contents as seen through each DUT's write port.
    logic [31:0] rf0 [32];
    logic [31:0] rf1 [32];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input int k);
        if (rst) return -1;
        if (v0[k] && v1[k]) return (k == 1 || m_last[k]) ? 0 : 1;
        if (v0[k]) return 0;
        if (v1[k]) return 1;
        return -1;
    endfunction

    task automatic check_inst(input int k, input string nm, input logic r0, input logic r1,
                              input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                              input logic lg);
        int gg;
        gg = model_grant(k);
        check({nm, ".req0_ready"}, r0, gg == 0);
        check({nm, ".req1_ready"}, r1, gg == 1);
        check({nm, ".rf_wen"}, wen, m_wen[k]);
        check({nm, ".rf_waddr"}, wa, m_waddr[k]);
        check({nm, ".rf_wdata"}, wd, m_wdata[k]);
        check({nm, ".last_grant"}, lg, m_last[k]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1'b1;
            m_wen[k] = 1'b0;
            m_waddr[k] = '0;
            m_wdata[k] = '0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic drive(input logic q0, input logic [4:0] qa0, input logic [31:0] qd0,
                         input logic q1, input logic [4:0] qa1, input logic [31:0] qd1);
        for (int k = 0; k < 2; k++) begin
            v0[k] = q0; a0[k] = qa0; d0[k] = qd0;
            v1[k] = q1; a1[k] = qa1; d1[k] = qd1;
        end
    endtask

    // mode 0: hold stimulus; 1: drop accepted requests; 2: refill with random requests.
    task automatic step(input int mode);
        @(negedge clk);
        check_inst(0, "rr", wb_rr.req0_ready, wb_rr.req1_ready, wb_rr.rf_wen, wb_rr.rf_waddr,
                   wb_rr.rf_wdata, wb_rr.last_grant);
        check_inst(1, "fp", wb_fp.req0_ready, wb_fp.req1_ready, wb_fp.rf_wen, wb_fp.rf_waddr,
                   wb_fp.rf_wdata, wb_fp.last_grant);
`ifdef RF_WB_ARB_STATS_EN
        check("rr.conflict_cnt", cnt_rr, m_cnt[0]);
        check("fp.conflict_cnt", cnt_fp, m_cnt[1]);
`endif
        if (wb_rr.rf_wen) rf0[wb_rr.rf_waddr] = wb_rr.rf_wdata;
        if (wb_fp.rf_wen) rf1[wb_fp.rf_waddr] = wb_fp.rf_wdata;
        for (int k = 0; k < 2; k++) g[k] = model_grant(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_last[k] = 1'b1; m_wen[k] = 1'b0; m_waddr[k] = '0; m_wdata[k] = '0; m_cnt[k] = 0;
            end else begin
                if (v0[k] && v1[k] && m_cnt[k] < 65535) m_cnt[k]++;
                if (g[k] >= 0) begin
                    m_last[k]  = (g[k] == 1);
                    m_waddr[k] = (g[k] == 1) ? a1[k] : a0[k];
                    m_wdata[k] = (g[k] == 1) ? d1[k] : d0[k];
                    m_wen[k]   = (m_waddr[k] != 0);
                end else begin
                    m_wen[k] = 1'b0;
                end
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            if (mode == 1) begin
                if (g[k] == 0) v0[k] = 1'b0;
                if (g[k] == 1) v1[k] = 1'b0;
            end else if (mode == 2) begin
                if (!v0[k] || g[k] == 0) begin
                    v0[k] = ($urandom_range(0, 9) < 6);
                    a0[k] = 5'($urandom_range(0, 7));
                    d0[k] = $urandom;
                end
                if (!v1[k] || g[k] == 1) begin
                    v1[k] = ($urandom_range(0, 9) < 6);
                    a1[k] = 5'($urandom_range(0, 7));
                    d1[k] = $urandom;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf0[i] = '0;
            rf1[i] = '0;
        end
        for (int k = 0; k < 2; k++) g[k] = -1;
        model_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;

        // Reset, then a single req0 write.
        step(0);
        step(0);
        rst = 1'b0;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        step(0);
        check("single.rf_wen", wb_rr.rf_wen, 1'b1);
        check("single.rf_waddr", wb_rr.rf_waddr, 5'd5);
        check("single.rf_wdata", wb_rr.rf_wdata, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step(0);
        check("single.rf_wen_after", wb_rr.rf_wen, 1'b0);

        // Continuous tie from a fresh reset, then req0 drops.
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        for (int i = 0; i < 4; i++) step(0);
        check("tie.rr_last_grant", wb_rr.last_grant, 1'b1);
        check("tie.fp_last_grant", wb_fp.last_grant, 1'b0);
        drive(1'b0, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        step(0);
        check("tie.fp_last_after_drop", wb_fp.last_grant, 1'b1);

        // Write to register 0 is acknowledged but dropped.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        step(0);
        check("r0.rf_wen", wb_rr.rf_wen, 1'b0);
        check("r0.rf_waddr", wb_rr.rf_waddr, 5'd0);
        check("r0.last_grant", wb_rr.last_grant, 1'b1);

        // Both requesters target the same register after reset.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        for (int i = 0; i < 4; i++) step(1);
        check("same.rr_rf7", rf0[7], 32'hB);
        check("same.fp_rf7", rf1[7], 32'hB);

        // Reset asserted on the cycle req0 would be granted.
        drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        check("rstmid.rf_wen", wb_rr.rf_wen, 1'b0);
        check("rstmid.last_grant", wb_rr.last_grant, 1'b1);
        step(1);
        step(0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            step(2);
        end
        rst = 1'b0;

`ifdef RF_WB_ARB_STATS_EN
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
        for (int i = 0; i < 10; i++) step(0);
        check("stats.cnt10", cnt_rr, 16'd10);
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        check("stats.cnt_after_rst", cnt_rr, 16'd0);
`endif

        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step(0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
